// File: rtl/result_stage.sv
`default_nettype none
// ============================================================================
// Module      : result_stage
// Description : Writeback result stage. Holds the ALU-out register, extracts
//               and extends load data from an aligned memory word, selects the
//               writeback source, and presents a one-entry valid/ready
//               writeback slot to the register file.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : XLEN  - datapath width (32 or 64 only)
//               RD_W  - destination-register index width
// Ports       : clk        - clock, all state updates on rising edge
//               reset      - synchronous active-high reset
//               alu_result - combinational ALU output
//               alu_en     - capture enable for the ALU-out register
//               mem_rdata  - raw aligned memory read word
//               load_fmt   - load format (RISC-V funct3 encoding)
//               byte_off   - low address bits of the load
//               pc_next    - PC+4 link value for JAL/JALR
//               imm        - immediate for LUI
//               result_sel - result source select
//               in_valid   - writeback request presented
//               in_rd      - destination register of the request
//               in_ready   - stage accepts a request this cycle
//               result     - combinational selected result
//               wb_valid   - writeback slot holds data
//               wb_rd      - destination register of the slot
//               wb_data    - data of the slot
//               wb_ready   - register file consumes the slot this cycle
// ============================================================================
module result_stage #(
    parameter  int XLEN  = 32,
    parameter  int RD_W  = 5,
    localparam int OFF_W = $clog2(XLEN / 8)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   alu_result,
    input  logic              alu_en,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic [2:0]        load_fmt,
    input  logic [OFF_W-1:0]  byte_off,
    input  logic [XLEN-1:0]   pc_next,
    input  logic [XLEN-1:0]   imm,
    input  logic [2:0]        result_sel,
    input  logic              in_valid,
    input  logic [RD_W-1:0]   in_rd,
    output logic              in_ready,
    output logic [XLEN-1:0]   result,
    output logic              wb_valid,
    output logic [RD_W-1:0]   wb_rd,
    output logic [XLEN-1:0]   wb_data,
    input  logic              wb_ready
);

    // Result source select encodings
    localparam logic [2:0] c_SEL_ALU_OUT = 3'd0;
    localparam logic [2:0] c_SEL_LOAD    = 3'd1;
    localparam logic [2:0] c_SEL_ALU_RES = 3'd2;
    localparam logic [2:0] c_SEL_LAST    = 3'd3;
    localparam logic [2:0] c_SEL_PC_NEXT = 3'd4;
    localparam logic [2:0] c_SEL_IMM     = 3'd5;

    logic [XLEN-1:0] r_alu_out;
    logic [XLEN-1:0] r_last_result;
    logic [XLEN-1:0] r_wb_data;
    logic [RD_W-1:0] r_wb_rd;
    logic            r_wb_valid;

    logic [OFF_W+2:0] w_shamt;
    logic [XLEN-1:0]  w_sh;
    logic [XLEN-1:0]  w_sext_word;   // sh[31:0] sign-extended to XLEN
    logic [XLEN-1:0]  w_zext_word;   // sh[31:0] zero-extended to XLEN
    logic [XLEN-1:0]  w_fmt_dword;   // value for the 011 (doubleword) format
    logic [XLEN-1:0]  w_load;
    logic             w_accept;

    // ------------------------------------------------------------------
    // Load extraction: right-shift by whole bytes, vacated bits zero.
    // Misaligned offsets are not trapped; the zero fill simply flows into
    // the extension (e.g. half-word at offset 3 sees bit 15 = 0).
    // ------------------------------------------------------------------
    assign w_shamt = {byte_off, 3'b000};
    assign w_sh    = mem_rdata >> w_shamt;

    // Word-sized extension only does anything on a 64-bit datapath; on a
    // 32-bit datapath the doubleword format falls back to the word load.
    generate
        if (XLEN == 64) begin : g_rv64
            assign w_sext_word = {{(XLEN-32){w_sh[31]}}, w_sh[31:0]};
            assign w_zext_word = {{(XLEN-32){1'b0}},     w_sh[31:0]};
            assign w_fmt_dword = w_sh;
        end else begin : g_rv32
            assign w_sext_word = w_sh;
            assign w_zext_word = w_sh;
            assign w_fmt_dword = w_sh;
        end
    endgenerate

    always_comb begin
        w_load = w_sext_word;
        case (load_fmt)
            3'b000:  w_load = {{(XLEN-8){w_sh[7]}},   w_sh[7:0]};
            3'b001:  w_load = {{(XLEN-16){w_sh[15]}}, w_sh[15:0]};
            3'b010:  w_load = w_sext_word;
            3'b011:  w_load = w_fmt_dword;
            3'b100:  w_load = {{(XLEN-8){1'b0}},  w_sh[7:0]};
            3'b101:  w_load = {{(XLEN-16){1'b0}}, w_sh[15:0]};
            3'b110:  w_load = w_zext_word;
            default: w_load = w_sext_word;
        endcase
    end

    // ------------------------------------------------------------------
    // Result select. Select 3 reads the registered copy of the previous
    // result, so there is no combinational loop through the mux.
    // ------------------------------------------------------------------
    always_comb begin
        result = '0;
        case (result_sel)
            c_SEL_ALU_OUT: result = r_alu_out;
            c_SEL_LOAD:    result = w_load;
            c_SEL_ALU_RES: result = alu_result;
            c_SEL_LAST:    result = r_last_result;
            c_SEL_PC_NEXT: result = pc_next;
            c_SEL_IMM:     result = imm;
            default:       result = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Writeback slot: one entry, refillable in the same cycle it drains.
    // ------------------------------------------------------------------
    assign in_ready = !r_wb_valid || wb_ready;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_alu_out     <= '0;
            r_last_result <= '0;
            r_wb_data     <= '0;
            r_wb_rd       <= '0;
            r_wb_valid    <= 1'b0;
        end else begin
            if (alu_en) begin
                r_alu_out <= alu_result;
            end
            if (result_sel != c_SEL_LAST) begin
                r_last_result <= result;
            end
            // Requests to x0 are accepted but never occupy the slot.
            if (w_accept && (in_rd != '0)) begin
                r_wb_data  <= result;
                r_wb_rd    <= in_rd;
                r_wb_valid <= 1'b1;
            end else if (r_wb_valid && wb_ready) begin
                r_wb_valid <= 1'b0;
            end
        end
    end

    assign wb_valid = r_wb_valid;
    assign wb_rd    = r_wb_rd;
    assign wb_data  = r_wb_data;

endmodule
`default_nettype wire

// File: tb/tb_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_stage
// Description : Scoreboard bench for result_stage. A 32-bit instance gets
//               directed and random stimulus against a reference model; a
//               64-bit instance exercises the doubleword load formats.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_stage;

    localparam int XLEN = 32;
    localparam int RD_W = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [XLEN-1:0]   alu_result;
    logic              alu_en;
    logic [XLEN-1:0]   mem_rdata;
    logic [2:0]        load_fmt;
    logic [1:0]        byte_off;
    logic [XLEN-1:0]   pc_next;
    logic [XLEN-1:0]   imm;
    logic [2:0]        result_sel;
    logic              in_valid;
    logic [RD_W-1:0]   in_rd;
    logic              in_ready;
    logic [XLEN-1:0]   result;
    logic              wb_valid;
    logic [RD_W-1:0]   wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              wb_ready;

    // 64-bit instance, load path only
    logic [63:0]       mem64;
    logic [2:0]        fmt64;
    logic [2:0]        off64;
    logic              in_ready64;
    logic [63:0]       result64;
    logic              wb_valid64;
    logic [RD_W-1:0]   wb_rd64;
    logic [63:0]       wb_data64;

    result_stage #(.XLEN(XLEN), .RD_W(RD_W)) dut (
        .clk(clk), .reset(reset), .alu_result(alu_result), .alu_en(alu_en),
        .mem_rdata(mem_rdata), .load_fmt(load_fmt), .byte_off(byte_off),
        .pc_next(pc_next), .imm(imm), .result_sel(result_sel),
        .in_valid(in_valid), .in_rd(in_rd), .in_ready(in_ready),
        .result(result), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_ready(wb_ready)
    );

    result_stage #(.XLEN(64), .RD_W(RD_W)) dut64 (
        .clk(clk), .reset(reset), .alu_result(64'd0), .alu_en(1'b0),
        .mem_rdata(mem64), .load_fmt(fmt64), .byte_off(off64),
        .pc_next(64'd0), .imm(64'd0), .result_sel(3'd1),
        .in_valid(1'b0), .in_rd(5'd0), .in_ready(in_ready64),
        .result(result64), .wb_valid(wb_valid64), .wb_rd(wb_rd64),
        .wb_data(wb_data64), .wb_ready(1'b1)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [RD_W-1:0] rd;
        logic [XLEN-1:0] data;
    } wb_t;

    wb_t sb_q[$];

    // Reference state
    logic [XLEN-1:0] m_alu_out;
    logic [XLEN-1:0] m_last;
    logic            m_valid;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Two's-complement sign extension of a bits-wide value, by arithmetic.
    function automatic logic [63:0] sext(input logic [63:0] v, input int bits);
        logic [63:0] half;
        logic [63:0] full;
        half = 64'd1 << (bits - 1);
        full = 64'd1 << bits;
        if (v >= half) return v - full;
        return v;
    endfunction

    function automatic logic [31:0] exp_load32(input logic [31:0] w, input logic [2:0] f,
                                               input logic [1:0] off);
        logic [63:0] sh;
        logic [63:0] v;
        sh = {32'd0, w} >> (8 * int'(off));
        case (f)
            3'd0:    v = sext(sh % 64'd256, 8);
            3'd1:    v = sext(sh % 64'd65536, 16);
            3'd4:    v = sh % 64'd256;
            3'd5:    v = sh % 64'd65536;
            default: v = sh % 64'h1_0000_0000;   // word formats all equal sh on 32 bits
        endcase
        return v[31:0];
    endfunction

    function automatic logic [31:0] exp_result();
        case (result_sel)
            3'd0:    return m_alu_out;
            3'd1:    return exp_load32(mem_rdata, load_fmt, byte_off);
            3'd2:    return alu_result;
            3'd3:    return m_last;
            3'd4:    return pc_next;
            3'd5:    return imm;
            default: return 32'd0;
        endcase
    endfunction

    // Check the current cycle against the model, advance the model, clock.
    task automatic cycle();
        logic [31:0] er;
        logic        er_ready;
        #1;
        er       = exp_result();
        er_ready = !m_valid || wb_ready;
        if (!reset) begin
            chk("result",   64'(result),   64'(er));
            chk("in_ready", 64'(in_ready), 64'(er_ready));
            chk("wb_valid", 64'(wb_valid), 64'(m_valid));
        end
        if (reset) begin
            m_valid   = 1'b0;
            m_alu_out = '0;
            m_last    = '0;
            sb_q.delete();
        end else begin
            if (in_valid && er_ready && (in_rd != 0)) begin
                sb_q.push_back('{rd: in_rd, data: er});
                m_valid = 1'b1;
            end else if (m_valid && wb_ready) begin
                m_valid = 1'b0;
            end
            if (alu_en) m_alu_out = alu_result;
            if (result_sel != 3'd3) m_last = er;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every consumed slot must match the oldest expected entry.
    always @(negedge clk) begin : mon
        wb_t e;
        if (!reset && (wb_valid === 1'b1) && wb_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got rd=%0d data=0x%0h expected no slot", wb_rd, wb_data);
            end else begin
                e = sb_q.pop_front();
                chk("wb_rd",   64'(wb_rd),   64'(e.rd));
                chk("wb_data", 64'(wb_data), 64'(e.data));
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset = 1'b1; alu_result = '0; alu_en = 1'b0; mem_rdata = '0; load_fmt = '0;
        byte_off = '0; pc_next = '0; imm = '0; result_sel = '0; in_valid = 1'b0;
        in_rd = '0; wb_ready = 1'b0; mem64 = '0; fmt64 = '0; off64 = '0;
        m_alu_out = '0; m_last = '0; m_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        #1;
        chk("rst_wb_valid", 64'(wb_valid), 64'(1'b0));
        chk("rst_in_ready", 64'(in_ready), 64'(1'b1));
        chk("rst_wb_rd",    64'(wb_rd),    64'(0));
        chk("rst_wb_data",  64'(wb_data),  64'(0));
        chk("rst_alu_out",  64'(result),   64'(0));
        result_sel = 3'd3;
        #1 chk("rst_last", 64'(result), 64'(0));

        // Load extraction, 32-bit
        result_sel = 3'd1; mem_rdata = 32'h80F0_7F01;
        load_fmt = 3'b000; byte_off = 2'd1;
        #1 chk("ld_b_off1",  64'(result), 64'(32'h0000_007F));
        byte_off = 2'd2;
        #1 chk("ld_b_off2",  64'(result), 64'(32'hFFFF_FFF0));
        load_fmt = 3'b101;
        #1 chk("ld_hu_off2", 64'(result), 64'(32'h0000_80F0));
        load_fmt = 3'b001; byte_off = 2'd3;
        #1 chk("ld_h_off3_misaligned", 64'(result), 64'(32'h0000_0080));
        cycle();

        // ALU-out register vs live ALU result
        alu_result = 32'h1234; alu_en = 1'b1; result_sel = 3'd2;
        cycle();
        alu_result = 32'h9999; alu_en = 1'b0; result_sel = 3'd0;
        #1 chk("alu_out_held", 64'(result), 64'(32'h1234));
        result_sel = 3'd2;
        #1 chk("alu_live", 64'(result), 64'(32'h9999));
        cycle();

        // Last-result hold
        result_sel = 3'd5; imm = 32'hABCD_0000;
        cycle();
        result_sel = 3'd3;
        for (int i = 0; i < 3; i++) begin
            imm = $urandom;
            #1 chk("last_hold", 64'(result), 64'(32'hABCD_0000));
            cycle();
        end

        // Back-to-back writebacks
        wb_ready = 1'b1; in_valid = 1'b1; result_sel = 3'd2;
        for (int k = 1; k <= 4; k++) begin
            in_rd = RD_W'(k); alu_result = $urandom;
            cycle();
            chk("b2b_wb_rd",    64'(wb_rd),    64'(k));
            chk("b2b_wb_valid", 64'(wb_valid), 64'(1'b1));
        end
        in_valid = 1'b0;
        cycle();

        // Stall while rd=2 is held
        in_valid = 1'b1; in_rd = 5'd1; alu_result = $urandom;
        cycle();
        in_rd = 5'd2; alu_result = $urandom;
        cycle();
        wb_ready = 1'b0; in_rd = 5'd3; alu_result = $urandom;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_in_ready", 64'(in_ready), 64'(1'b0));
            chk("stall_wb_rd",    64'(wb_rd),    64'(2));
            cycle();
        end
        wb_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();

        // Request to x0 is discarded
        in_valid = 1'b1; in_rd = 5'd0;
        cycle();
        in_valid = 1'b0;
        chk("rd0_wb_valid", 64'(wb_valid), 64'(1'b0));

        // Reset during a stalled slot
        in_valid = 1'b1; in_rd = 5'd5;
        cycle();
        in_valid = 1'b0; wb_ready = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        chk("rst_stall_wb_valid", 64'(wb_valid), 64'(1'b0));
        chk("rst_stall_in_ready", 64'(in_ready), 64'(1'b1));
        cycle();

        // 64-bit load formats
        mem64 = 64'hFFFF_FFFF_8000_0000; off64 = 3'd0;
        fmt64 = 3'b010;
        #1 chk("ld64_w",  result64, 64'hFFFF_FFFF_8000_0000);
        fmt64 = 3'b110;
        #1 chk("ld64_wu", result64, 64'h0000_0000_8000_0000);
        fmt64 = 3'b011;
        #1 chk("ld64_d",  result64, 64'hFFFF_FFFF_8000_0000);
        fmt64 = 3'b000; off64 = 3'd4;
        #1 chk("ld64_b_off4", result64, 64'hFFFF_FFFF_FFFF_FFFF);
        fmt64 = 3'b101; off64 = 3'd2;
        #1 chk("ld64_hu_off2", result64, 64'h0000_0000_0000_8000);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            reset      = ($urandom_range(0, 49) == 0);
            in_valid   = 1'($urandom_range(0, 1));
            in_rd      = RD_W'($urandom_range(0, 7));
            wb_ready   = ($urandom_range(0, 9) < 7);
            result_sel = 3'($urandom_range(0, 7));
            alu_en     = 1'($urandom_range(0, 1));
            alu_result = $urandom;
            mem_rdata  = $urandom;
            load_fmt   = 3'($urandom_range(0, 7));
            byte_off   = 2'($urandom_range(0, 3));
            pc_next    = $urandom;
            imm        = $urandom;
            cycle();
        end

        // Drain and confirm nothing is left outstanding
        reset = 1'b0; in_valid = 1'b0; wb_ready = 1'b1;
        cycle();
        cycle();
        chk("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
